// File: rtl/sequenciador_exibicao.sv
// sequenciador_exibicao: round controller for the mindfocus game.
// Latches a 4-position stimulus and shows it one position at a time on
// one-hot LEDs, with a blank gap after each position. It then collects
// four button plays, each with a response timeout, and counts the hits.
//
// Ports:
//   clock       system clock
//   reset       synchronous, active-high
//   iniciar     start/restart request (level sampled in INICIAL and FIM)
//   botoes[3:0] player buttons, already synchronized
//   indices[7:0] stimulus, position k = indices[2k+1:2k]
//   leds[3:0]   one-hot position display
//   acertos[3:0] hits in this round (0..4)
//   pronto      round finished
//   jogando     high in every state except INICIAL and FIM
//   db_timeout  one-cycle pulse for each play timeout
//   db_posicao  current position k
//   db_estado   state code
module sequenciador_exibicao #(
  parameter int T_EXIBE    = 1000,
  parameter int T_PAUSA    = 250,
  parameter int T_RESPOSTA = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] botoes,
  input  logic [7:0] indices,
  output logic [3:0] leds,
  output logic [3:0] acertos,
  output logic       pronto,
  output logic       jogando,
  output logic       db_timeout,
  output logic [1:0] db_posicao,
  output logic [3:0] db_estado
);

  localparam int T_MAX_EP = (T_EXIBE > T_PAUSA) ? T_EXIBE : T_PAUSA;
  localparam int T_MAX    = (T_MAX_EP > T_RESPOSTA) ? T_MAX_EP : T_RESPOSTA;
  // Largest terminal value is T_MAX-1.
  localparam int TW       = $clog2(T_MAX);

  localparam logic [TW-1:0] FIM_EXIBE    = TW'(T_EXIBE - 1);
  localparam logic [TW-1:0] FIM_PAUSA    = TW'(T_PAUSA - 1);
  localparam logic [TW-1:0] FIM_RESPOSTA = TW'(T_RESPOSTA - 1);

  localparam logic [3:0] INICIAL  = 4'd0;
  localparam logic [3:0] PREPARA  = 4'd1;
  localparam logic [3:0] EXIBE    = 4'd2;
  localparam logic [3:0] PAUSA    = 4'd3;
  localparam logic [3:0] ESPERA   = 4'd4;
  localparam logic [3:0] REGISTRA = 4'd5;
  localparam logic [3:0] SOLTA    = 4'd6;
  localparam logic [3:0] PROXIMA  = 4'd7;
  localparam logic [3:0] FIM      = 4'd8;

  logic [3:0]    estado, estado_prox;
  logic [TW-1:0] timer;
  logic [1:0]    k;
  logic [3:0]    acertos_q;
  logic [7:0]    idx_lat;
  logic          armado;
  logic [3:0]    jogada;
  logic          timeout_q;

  logic          jogada_valida;
  logic          estouro;
  logic [1:0]    idx_atual;
  logic [3:0]    alvo;
  logic          estado_valido;

  assign idx_atual = idx_lat[{k, 1'b0} +: 2];
  assign alvo      = 4'b0001 << idx_atual;

  always_comb begin
    estado_prox   = estado;
    jogada_valida = 1'b0;
    estouro       = 1'b0;
    case (estado)
      INICIAL:  if (iniciar) estado_prox = PREPARA;
      PREPARA:  estado_prox = EXIBE;
      EXIBE:    if (timer == FIM_EXIBE) estado_prox = PAUSA;
      PAUSA:    if (timer == FIM_PAUSA) estado_prox = (k == 2'd3) ? ESPERA : EXIBE;
      ESPERA: begin
        // A press wins over a timeout landing on the same cycle.
        if (armado && (botoes != 4'b0000)) begin
          estado_prox   = REGISTRA;
          jogada_valida = 1'b1;
        end else if (timer == FIM_RESPOSTA) begin
          estado_prox = PROXIMA;
          estouro     = 1'b1;
        end
      end
      REGISTRA: estado_prox = SOLTA;
      SOLTA:    if (botoes == 4'b0000) estado_prox = PROXIMA;
      PROXIMA:  estado_prox = (k == 2'd3) ? FIM : ESPERA;
      FIM:      if (iniciar) estado_prox = PREPARA;
      default:  estado_prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= INICIAL;
      timer     <= '0;
      k         <= '0;
      acertos_q <= '0;
      idx_lat   <= '0;
      armado    <= 1'b0;
      jogada    <= '0;
      timeout_q <= 1'b0;
    end else begin
      estado    <= estado_prox;
      // Timer restarts on every state change.
      timer     <= (estado_prox != estado) ? '0 : timer + 1'b1;
      timeout_q <= estouro;
      case (estado)
        INICIAL, FIM: begin
          // Clearing on the way into PREPARA lets pronto and acertos drop together.
          if (iniciar) begin
            k         <= '0;
            acertos_q <= '0;
          end
        end
        PREPARA: idx_lat <= indices;
        PAUSA: begin
          if (timer == FIM_PAUSA) begin
            if (k == 2'd3) begin
              k      <= '0;
              armado <= 1'b0;
            end else begin
              k <= k + 2'd1;
            end
          end
        end
        ESPERA: begin
          // A button already held on entry must be released before it counts.
          if (botoes == 4'b0000) armado <= 1'b1;
          if (jogada_valida) jogada <= botoes;
        end
        REGISTRA: if (jogada == alvo) acertos_q <= acertos_q + 4'd1;
        PROXIMA: begin
          if (k != 2'd3) begin
            k      <= k + 2'd1;
            armado <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign estado_valido = (estado <= FIM);

  assign leds       = (estado == EXIBE) ? alvo : 4'b0000;
  assign acertos    = acertos_q;
  assign pronto     = (estado == FIM);
  assign jogando    = estado_valido && (estado != INICIAL) && (estado != FIM);
  assign db_timeout = timeout_q;
  assign db_posicao = (estado_valido && (estado != INICIAL)) ? k : 2'd0;
  assign db_estado  = estado_valido ? estado : INICIAL;

endmodule

// File: tb/tb_sequenciador_exibicao.sv
// Directed bench for sequenciador_exibicao with short timings
// (T_EXIBE=4, T_PAUSA=2, T_RESPOSTA=8).
module tb_sequenciador_exibicao;

  localparam int TE = 4;
  localparam int TP = 2;
  localparam int TR = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] botoes;
  logic [7:0] indices;
  logic [3:0] leds;
  logic [3:0] acertos;
  logic       pronto;
  logic       jogando;
  logic       db_timeout;
  logic [1:0] db_posicao;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int n_timeout = 0;
  int base_timeout;

  localparam logic [7:0] IDX = 8'b11_10_01_00;

  sequenciador_exibicao #(
    .T_EXIBE(TE),
    .T_PAUSA(TP),
    .T_RESPOSTA(TR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .iniciar(iniciar),
    .botoes(botoes),
    .indices(indices),
    .leds(leds),
    .acertos(acertos),
    .pronto(pronto),
    .jogando(jogando),
    .db_timeout(db_timeout),
    .db_posicao(db_posicao),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (db_timeout === 1'b1) n_timeout++;

  task automatic verifica(input string tag, input int obs, input int esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  task automatic passo();
    @(posedge clock);
    #1;
  endtask

  function automatic int saidas();
    return int'({leds, acertos, pronto, jogando, db_timeout, db_posicao, db_estado});
  endfunction

  // Checks a whole display sequence starting right after the PREPARA cycle.
  task automatic exibe(input logic [7:0] idx, input bit embaralha,
                       input bit pulsa_iniciar, input logic [3:0] botao_final);
    logic [3:0] esperado;
    for (int p = 0; p < 4; p++) begin
      esperado = 4'b0001 << idx[2*p +: 2];
      for (int c = 0; c < TE; c++) begin
        passo();
        verifica("exibe_leds", int'(leds), int'(esperado));
        verifica("exibe_estado", int'(db_estado), 2);
        verifica("exibe_pos", int'(db_posicao), p);
        if (embaralha && p == 1 && c == 0) indices = 8'b00_11_00_11;
        iniciar = (pulsa_iniciar && p == 1 && c == 1);
      end
      for (int c = 0; c < TP; c++) begin
        passo();
        verifica("pausa_leds", int'(leds), 0);
        verifica("pausa_estado", int'(db_estado), 3);
        if (p == 3 && c == 0) botoes = botao_final;
      end
    end
    passo();
    verifica("espera_entrada", int'(db_estado), 4);
    verifica("espera_jogando", int'(jogando), 1);
    indices = idx;
  endtask

  // One play from an ESPERA cycle with buttons released.
  task automatic joga(input logic [3:0] btn, input bit ultima);
    passo();
    verifica("joga_arma", int'(db_estado), 4);
    botoes = btn;
    passo();
    verifica("joga_registra", int'(db_estado), 5);
    passo();
    verifica("joga_solta", int'(db_estado), 6);
    passo();
    verifica("joga_segura", int'(db_estado), 6);
    botoes = 4'b0000;
    passo();
    verifica("joga_proxima", int'(db_estado), 7);
    passo();
    verifica("joga_seguinte", int'(db_estado), ultima ? 8 : 4);
  endtask

  // Lets every remaining play of the round time out.
  task automatic estoura_todas();
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < TR - 1; c++) begin
        passo();
        verifica("to_espera", int'(db_estado), 4);
        verifica("to_pulso_baixo", int'(db_timeout), 0);
      end
      passo();
      verifica("to_proxima", int'(db_estado), 7);
      verifica("to_pulso", int'(db_timeout), 1);
      passo();
      verifica("to_depois", int'(db_estado), (t == 3) ? 8 : 4);
      verifica("to_pulso_fim", int'(db_timeout), 0);
    end
  endtask

  task automatic comeca();
    iniciar = 1'b1;
    passo();
    verifica("prepara_estado", int'(db_estado), 1);
    verifica("prepara_pronto", int'(pronto), 0);
    verifica("prepara_acertos", int'(acertos), 0);
    iniciar = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    iniciar = 1'b0;
    botoes  = 4'b0000;
    indices = IDX;

    // 1: reset and idle
    passo();
    passo();
    verifica("reset_saidas", saidas(), 0);
    reset = 1'b0;
    passo();
    passo();
    verifica("idle_saidas", saidas(), 0);

    // 2: display, indices scrambled mid-display
    comeca();
    exibe(IDX, 1'b1, 1'b0, 4'b0000);

    // 3: four correct plays
    base_timeout = n_timeout;
    joga(4'b0001, 1'b0);
    joga(4'b0010, 1'b0);
    joga(4'b0100, 1'b0);
    joga(4'b1000, 1'b1);
    verifica("c3_acertos", int'(acertos), 4);
    verifica("c3_pronto", int'(pronto), 1);
    verifica("c3_jogando", int'(jogando), 0);
    verifica("c3_sem_timeout", n_timeout - base_timeout, 0);

    // 4: hit, wrong, multi-button, hit
    comeca();
    exibe(IDX, 1'b0, 1'b0, 4'b0000);
    joga(4'b0001, 1'b0);
    joga(4'b1000, 1'b0);
    joga(4'b0011, 1'b0);
    joga(4'b1000, 1'b1);
    verifica("c4_acertos", int'(acertos), 2);
    verifica("c4_pronto", int'(pronto), 1);

    // 5: no presses, all time out
    comeca();
    exibe(IDX, 1'b0, 1'b0, 4'b0000);
    base_timeout = n_timeout;
    estoura_todas();
    verifica("c5_pulsos", n_timeout - base_timeout, 4);
    verifica("c5_acertos", int'(acertos), 0);
    verifica("c5_pronto", int'(pronto), 1);

    // 5/6: restart, iniciar pulsed in EXIBE, button held into ESPERA
    comeca();
    exibe(IDX, 1'b0, 1'b1, 4'b0001);
    for (int c = 0; c < 3; c++) begin
      passo();
      verifica("seguro_sem_jogada", int'(db_estado), 4);
    end
    botoes = 4'b0000;
    passo();
    verifica("solto_espera", int'(db_estado), 4);
    botoes = 4'b0001;
    passo();
    verifica("c6_registra", int'(db_estado), 5);
    passo();
    verifica("c6_acertos", int'(acertos), 1);
    botoes = 4'b0000;
    for (int c = 0; c < 80 && db_estado != 4'd8; c++) passo();
    verifica("c6_fim", int'(db_estado), 8);
    verifica("c6_acertos_fim", int'(acertos), 1);

    // 6: reset while a position is lit
    comeca();
    passo();
    verifica("c6_leds_acesos", int'(leds), 1);
    reset = 1'b1;
    passo();
    verifica("reset_exibe", saidas(), 0);
    reset = 1'b0;
    passo();
    verifica("apos_reset", saidas(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequenciador_exibicao.md
Name: sequenciador_exibicao

Overview:
- Round controller for the mindfocus game. On each round it latches the 4-position stimulus (four 2-bit indices) from the datapath.
- It presents the positions one at a time on 4 one-hot LEDs, each for a programmed time with a blank gap between positions.
- It then collects 4 button plays, each with a response timeout, scores them and reports the hit count.
- It sits between the index generator in the datapath and the board I/O (botoes/LEDs), alongside the main control unit.

Parameters:
- T_EXIBE, 1000: cycles each position is lit.
- T_PAUSA, 250: blank cycles after each lit position.
- T_RESPOSTA, 5000: cycles allowed per play before timeout.
- Timer width: sized from the largest of the three parameters. Each parameter ≥ 2.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- iniciar  in  1  start/restart request (level sampled)
- botoes  in  4  player buttons, already synchronized
- indices  in  8  stimulus; position k = indices[2k+1:2k]
- leds  out  4  one-hot position display
- acertos  out  4  hits this round, 0..4
- pronto  out  1  round finished
- jogando  out  1  high in every state except INICIAL and FIM
- db_timeout  out  1  one-cycle pulse on each play timeout
- db_posicao  out  2  current position k
- db_estado  out  4  state code

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - reset=1 at a rising edge, from any state (including mid-display or mid-play), gives INICIAL.
  - It also clears the timer, k, acertos, the latched indices, the armed flag and the latched jogada.
  - All outputs are 0 during and after reset.
- Output style: all outputs are Moore, registered or decoded from registered state. No combinational path from botoes to any output.
- States (db_estado code):
  - INICIAL=0:
    - All outputs 0.
    - iniciar=1 → PREPARA.
  - PREPARA=1 (1 cycle):
    - Latch indices; k=0; acertos=0; timer=0.
    - → EXIBE.
    - Later changes on indices are ignored until the next PREPARA.
  - EXIBE=2:
    - leds = 1<<idx[k] for exactly T_EXIBE cycles.
    - Timer = T_EXIBE-1 → PAUSA, timer=0.
  - PAUSA=3:
    - leds=0 for exactly T_PAUSA cycles.
    - At the end: if k=3 → ESPERA with k=0 and armed=0; else k=k+1 → EXIBE.
  - ESPERA=4:
    - leds=0. Timer counts.
    - armed is set on any cycle with botoes=0. A button held on entry is not a play until it is released.
    - If armed=1 and botoes≠0: latch jogada=botoes → REGISTRA. The press is taken in preference to timeout when both happen in the same cycle.
    - Otherwise, timer = T_RESPOSTA-1 → PROXIMA with db_timeout=1 for that transition cycle. The play counts as a miss.
  - REGISTRA=5 (1 cycle):
    - If jogada == 1<<idx[k], acertos=acertos+1.
    - A multi-button press (e.g. 0011) never equals a one-hot value, so it is a miss.
    - → SOLTA.
  - SOLTA=6: wait for botoes=0 → PROXIMA. No timeout applies here.
  - PROXIMA=7 (1 cycle):
    - If k=3 → FIM.
    - Else k=k+1, timer=0, armed=0 → ESPERA.
  - FIM=8:
    - pronto=1 and acertos held.
    - iniciar=1 → PREPARA. This clears acertos and pronto on the next cycle.
- Other unused codes decode to INICIAL.
- iniciar is ignored in states 1–7.
- acertos saturates at 4 by construction; its upper bit is always 0.
- db_posicao = k in all states, and 0 in INICIAL.
- Timer: resets to 0 on every state entry. No wrap-around is observable.
- Latency (no presses): INICIAL→ESPERA takes 1 + 4·(T_EXIBE+T_PAUSA) cycles after iniciar is sampled.

Test Plan:
(Parameters T_EXIBE=4, T_PAUSA=2, T_RESPOSTA=8 for all scenarios.)
1. reset=1 for 2 cycles, then idle → leds=0, acertos=0, pronto=0, jogando=0, db_estado=0.
2. indices=8'b11_10_01_00, pulse iniciar →
   - 1 cycle PREPARA.
   - leds 0001×4, 0000×2, 0010×4, 0000×2, 0100×4, 0000×2, 1000×4, 0000×2.
   - Then db_estado=4.
   - indices changed mid-display has no effect.
3. Same stimulus; press 0001, 0010, 0100, 1000, each held 3 cycles then released → acertos=4, pronto=1, db_estado=8, no db_timeout pulse.
4. Same stimulus; plays 0001, 1000 (wrong), 0011 (multi), 1000 → acertos=2 at FIM.
5. No presses → db_timeout pulses 4 times, 8 cycles apart plus 1 PROXIMA cycle; acertos=0; pronto=1. Then iniciar → acertos=0, pronto=0, display restarts at position 0.
6. Boundary cases:
   - Button 0001 held from PAUSA into ESPERA → no play until release; the next press is scored.
   - iniciar pulsed during EXIBE → ignored.
   - reset asserted in EXIBE with leds≠0 → next cycle all outputs 0, db_estado=0.
